// File: rtl/fir_inverse.sv
// Inverse of the 3-tap FIR y = 2x[k-1] + 4x[k-2] + 6x[k-3]; recovers x[k-1] from y[k] with one cycle latency.
// Optional odd-residue consistency check and ERR state compiled in with FIR_INV_CHECK_EN.
module fir_inverse (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic signed [11:0] data_in,
    input  logic               clr,
    output logic signed [11:0] data_out,
    output logic               out_valid,
    output logic               err,
    output logic [15:0]        sample_cnt
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic signed [11:0] r_h1;
    logic signed [11:0] r_h2;
    logic signed [11:0] r_data_out;
    logic               r_out_valid;
    logic [15:0]        r_sample_cnt;

    logic [11:0]        w_h1x4;
    logic [11:0]        w_h2x6;
    logic [11:0]        w_residue;
    logic signed [11:0] w_x;
    logic               w_accept;
    logic               w_take;

    // All residue arithmetic wraps modulo 2^12, mirroring the forward filter's wrap.
    assign w_h1x4    = {r_h1[9:0], 2'b00};
    assign w_h2x6    = {r_h2[10:0], 1'b0} + {r_h2[9:0], 2'b00};
    assign w_residue = $unsigned(data_in) - w_h1x4 - w_h2x6;
    assign w_x       = $signed(w_residue) >>> 1;
    assign w_accept  = in_valid && !clr && (r_state == ST_RUN);

`ifdef FIR_INV_CHECK_EN
    logic r_err;
    logic w_set_err;

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_set_err    = 1'b0;
        if (clr) begin
            w_state_next = ST_RUN;
        end else if (w_accept) begin
            if (w_residue[0]) begin
                // An odd residue cannot come from the forward filter: drop it and lock up.
                w_state_next = ST_ERR;
                w_set_err    = 1'b1;
            end else begin
                w_take = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (clr) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    always_comb begin
        w_state_next = ST_RUN;
        w_take       = w_accept;
    end

    assign err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_h1         <= '0;
            r_h2         <= '0;
            r_data_out   <= '0;
            r_out_valid  <= 1'b0;
            r_sample_cnt <= '0;
        end else if (clr) begin
            r_h1         <= '0;
            r_h2         <= '0;
            r_data_out   <= '0;
            r_out_valid  <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_out_valid <= w_take;
            if (w_take) begin
                r_h2       <= r_h1;
                r_h1       <= w_x;
                r_data_out <= w_x;
                if (r_sample_cnt != 16'hFFFF) begin
                    r_sample_cnt <= r_sample_cnt + 16'd1;
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign out_valid  = r_out_valid;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_fir_inverse.sv
// Directed self-checking bench for fir_inverse; expectations hand-derived from the forward filter equation.
module tb_fir_inverse;

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic signed [11:0] data_in;
    logic               clr;
    logic signed [11:0] data_out;
    logic               out_valid;
    logic               err;
    logic [15:0]        sample_cnt;

    int n_tests;
    int n_fail;

    fir_inverse dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .clr        (clr),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .err        (err),
        .sample_cnt (sample_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one valid sample, then reports what the DUT produced after the edge.
    task automatic send(input int y);
        in_valid = 1'b1;
        data_in  = 12'(y);
        step();
        in_valid = 1'b0;
        $display("[TB] y=%0d -> data_out=%0d out_valid=%0b err=%0b cnt=%0d",
                 y, data_out, out_valid, err, sample_cnt);
    endtask

    task automatic send_chk(input string tag, input int y, input int x);
        send(y);
        check({tag, ".valid"}, int'(out_valid), 1);
        check({tag, ".data"}, int'(data_out), x);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        $display("[TB] clr -> data_out=%0d out_valid=%0b err=%0b cnt=%0d",
                 data_out, out_valid, err, sample_cnt);
        check("clr.err", int'(err), 0);
        check("clr.cnt", int'(sample_cnt), 0);
        check("clr.data", int'(data_out), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".data"}, int'(data_out), 0);
        check({tag, ".valid"}, int'(out_valid), 0);
        check({tag, ".err"}, int'(err), 0);
        check({tag, ".cnt"}, int'(sample_cnt), 0);
    endtask

    int y_imp [6] = '{0, 20, 34, 248, 382, 600};
    int x_imp [6] = '{0, 10, -3, 100, 0, 0};

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;

        #12;
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // Impulse round-trip
        for (int i = 0; i < 6; i++) send_chk($sformatf("imp%0d", i), y_imp[i], x_imp[i]);
        check("imp.cnt", int'(sample_cnt), 6);
        check("imp.err", int'(err), 0);

        // Extreme range: y stream the forward filter emits for x = 1023, -1024, -1024
        do_clr();
        send_chk("ext0", 2046, 1023);
        send_chk("ext1", 2044, -1024);
        send_chk("ext2", -6, -1024);
        check("ext.err", int'(err), 0);
        // y = -2048 from zero history sits on the negative wrap boundary
        do_clr();
        send_chk("ext3", -2048, -1024);
        check("ext3.err", int'(err), 0);

        // Gapped input
        do_clr();
        for (int i = 0; i < 6; i++) begin
            send_chk($sformatf("gap%0d", i), y_imp[i], x_imp[i]);
            for (int g = 0; g < 3; g++) begin
                step();
                check($sformatf("gap%0d.idle_valid", i), int'(out_valid), 0);
                check($sformatf("gap%0d.hold", i), int'(data_out), x_imp[i]);
            end
        end
        check("gap.cnt", int'(sample_cnt), 6);

        // Error path
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        step();
        send(5);
`ifdef FIR_INV_CHECK_EN
        check("err.valid", int'(out_valid), 0);
        check("err.flag", int'(err), 1);
        check("err.cnt", int'(sample_cnt), 0);
        send(20);
        check("err.ignored_valid", int'(out_valid), 0);
        check("err.sticky", int'(err), 1);
        check("err.ignored_cnt", int'(sample_cnt), 0);
`else
        // Without the check, r = 5 gives x = 5 >>> 1 = 2; then r = 20 - 4*2 = 12 gives 6
        check("nochk.valid", int'(out_valid), 1);
        check("nochk.data", int'(data_out), 2);
        check("nochk.err", int'(err), 0);
        send_chk("nochk2", 20, 6);
        check("nochk.cnt", int'(sample_cnt), 2);
`endif
        do_clr();
        send_chk("err.recover", 20, 10);

        // clr / in_valid collision with non-zero history (h1=100, h2=-3)
        do_clr();
        for (int i = 0; i < 4; i++) send_chk($sformatf("col%0d", i), y_imp[i], x_imp[i]);
        clr      = 1'b1;
        in_valid = 1'b1;
        data_in  = 12'(20);
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        $display("[TB] clr+y=20 -> data_out=%0d out_valid=%0b cnt=%0d", data_out, out_valid, sample_cnt);
        check("col.valid", int'(out_valid), 0);
        check("col.cnt", int'(sample_cnt), 0);
        check("col.data", int'(data_out), 0);
        send_chk("col.next", 20, 10);
        check("col.next_cnt", int'(sample_cnt), 1);

        // Asynchronous reset between edges mid-stream
        do_clr();
        for (int i = 0; i < 3; i++) send_chk($sformatf("ar%0d", i), y_imp[i], x_imp[i]);
        #2 reset = 1'b0;
        #1;
        check_all_zero("areset");
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) send_chk($sformatf("arr%0d", i), y_imp[i], x_imp[i]);
        check("arr.cnt", int'(sample_cnt), 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
